// File: rtl/pad_share_arbiter.sv
// pad_share_arbiter
//   Shares one bidirectional pad cell among NREQ requesters. Ownership is granted
//   round-robin; every change of owner passes through an OE-low turnaround gap of
//   TURN_CYCLES cycles, so the pad is never driven while it changes hands.
//
// Ports
//   clk_i            clock
//   rst_i            synchronous reset, active-high
//   req_i            per-requester pad request (level)
//   oe_req_i         per-requester output enable request (owner only)
//   out_i            per-requester output data (owner only)
//   attr_i           per-requester pad attributes, req k = [k*PADATTR +: PADATTR]
//   gnt_o            one-hot grant, zero when the pad has no owner
//   in_o             pad input broadcast to all requesters (= pad_out_i)
//   pad_in_o         to pad cell pad_in_i
//   pad_oe_o         to pad cell pad_oe_i
//   pad_attributes_o to pad cell pad_attributes_i (registered)
//   pad_out_i        from pad cell pad_out_o
//
// Configuration
//   PAD_SHARE_PREEMPT_EN  when defined, an owner that has held the pad for HOLD_MAX
//                         grant cycles is revoked as soon as another requester waits.
module pad_share_arbiter #(
  parameter int unsigned           NREQ        = 4,
  parameter int unsigned           PADATTR     = 16,
  parameter int unsigned           TURN_CYCLES = 2,
  parameter int unsigned           HOLD_MAX    = 16,
  parameter logic [PADATTR-1:0]    RESET_ATTR  = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NREQ-1:0]           req_i,
  input  logic [NREQ-1:0]           oe_req_i,
  input  logic [NREQ-1:0]           out_i,
  input  logic [NREQ*PADATTR-1:0]   attr_i,
  output logic [NREQ-1:0]           gnt_o,
  output logic                      in_o,
  output logic                      pad_in_o,
  output logic                      pad_oe_o,
  output logic [PADATTR-1:0]        pad_attributes_o,
  input  logic                      pad_out_i
);

  localparam int unsigned IdxW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned HoldW = $clog2(HOLD_MAX + 1);
  localparam int unsigned TurnW = 4;

  typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_e;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    owner_q, owner_d;
  logic [IdxW-1:0]    rr_q, rr_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic [TurnW-1:0]   turn_q, turn_d;
  logic [PADATTR-1:0] attr_q, attr_d;

  logic               pick_valid;
  logic [IdxW-1:0]    pick_idx;
  logic [NREQ-1:0]    owner_onehot;
  logic               leave;
  logic               arb_go;

  // Index of requester (base + off) mod NREQ.
  function automatic logic [IdxW-1:0] rot_idx(input logic [IdxW-1:0] base,
                                              input int unsigned off);
    int unsigned s;
    s = (32'(base) + off) % NREQ;
    return IdxW'(s);
  endfunction

  function automatic logic [PADATTR-1:0] attr_of(input logic [IdxW-1:0] idx,
                                                 input logic [NREQ*PADATTR-1:0] attrs);
    logic [PADATTR-1:0] r;
    r = RESET_ATTR;
    for (int k = 0; k < NREQ; k++) begin
      if (idx == IdxW'(k)) r = attrs[k*PADATTR +: PADATTR];
    end
    return r;
  endfunction

  // Round-robin pick: first requester at or after rr_q. Scanning offsets from the
  // far end down lets the smallest offset overwrite the others.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[rot_idx(rr_q, i)]) begin
        pick_valid = 1'b1;
        pick_idx   = rot_idx(rr_q, i);
      end
    end
  end

  always_comb begin
    owner_onehot = '0;
    owner_onehot[owner_q] = 1'b1;
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      owner_q <= '0;
      rr_q    <= '0;
      hold_q  <= '0;
      turn_q  <= '0;
      attr_q  <= RESET_ATTR;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
      attr_q  <= attr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    leave   = 1'b0;
    arb_go  = 1'b0;

    unique case (state_q)
      StIdle: arb_go = 1'b1;

      StGrant: begin
        leave = ~req_i[owner_q];
`ifdef PAD_SHARE_PREEMPT_EN
        // Only revoke when someone else is actually waiting for the pad.
        if ((hold_q == HoldW'(HOLD_MAX)) && |(req_i & ~owner_onehot)) leave = 1'b1;
`endif
        if (leave) begin
          rr_d   = (owner_q == IdxW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
          hold_d = '0;
          if (TURN_CYCLES == 0) begin
            // No turnaround: a single idle cycle still separates two owners.
            state_d = StIdle;
          end else begin
            state_d = StTurn;
            turn_d  = TurnW'(1);
          end
        end else if (hold_q < HoldW'(HOLD_MAX)) begin
          hold_d = hold_q + 1'b1;
        end
      end

      StTurn: begin
        // Arbitration happens in the last turnaround cycle, so the gap is exact.
        if (turn_q >= TurnW'(TURN_CYCLES)) arb_go = 1'b1;
        else                               turn_d = turn_q + 1'b1;
      end

      default: state_d = StIdle;
    endcase

    if (arb_go) begin
      turn_d = '0;
      if (pick_valid) begin
        state_d = StGrant;
        owner_d = pick_idx;
        hold_d  = HoldW'(1);
      end else begin
        state_d = StIdle;
      end
    end

    attr_d = (state_d == StGrant) ? attr_of(owner_d, attr_i) : RESET_ATTR;
  end

`ifndef PAD_SHARE_PREEMPT_EN
  // Hold count is only consumed by preemption.
  logic unused_hold;
  assign unused_hold = ^hold_q;
`endif

  // Outputs.
  always_comb begin
    gnt_o    = '0;
    pad_oe_o = 1'b0;
    pad_in_o = 1'b0;
    if (state_q == StGrant) begin
      gnt_o[owner_q] = 1'b1;
      pad_oe_o       = oe_req_i[owner_q];
      pad_in_o       = out_i[owner_q] & oe_req_i[owner_q];
    end
    pad_attributes_o = attr_q;
    in_o             = pad_out_i;
  end

endmodule

// File: tb/tb_pad_share_arbiter.sv
module tb_pad_share_arbiter;
  localparam int N  = 4;
  localparam int PA = 16;
  localparam int TC = 2;
  localparam int HM = 16;
  localparam logic [PA-1:0] RA = '0;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [N-1:0]    req_i, oe_req_i, out_i;
  logic [N*PA-1:0] attr_i;
  logic            pad_out_i;
  logic [N-1:0]    gnt_o;
  logic            in_o, pad_in_o, pad_oe_o;
  logic [PA-1:0]   pad_attributes_o;

  pad_share_arbiter #(
    .NREQ(N), .PADATTR(PA), .TURN_CYCLES(TC), .HOLD_MAX(HM), .RESET_ATTR(RA)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .oe_req_i(oe_req_i), .out_i(out_i),
    .attr_i(attr_i), .gnt_o(gnt_o), .in_o(in_o), .pad_in_o(pad_in_o),
    .pad_oe_o(pad_oe_o), .pad_attributes_o(pad_attributes_o), .pad_out_i(pad_out_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the pad, how many gap cycles remain, how long the
  // owner has held it, where round-robin resumes, and the attribute latched.
  int            m_owner = -1;
  int            m_gap = 0;
  int            m_held = 0;
  int            m_rr = 0;
  logic [PA-1:0] m_attr = RA;
  bit            model_on = 1'b0;

  function automatic void model_step();
    bit leave;
    if (rst_i) begin
      m_owner = -1; m_gap = 0; m_held = 0; m_rr = 0; m_attr = RA;
      return;
    end
    if (m_owner >= 0) begin
      leave = !req_i[m_owner];
`ifdef PAD_SHARE_PREEMPT_EN
      if (m_held >= HM && (req_i & ~(N'(1) << m_owner)) != '0) leave = 1'b1;
`endif
      if (leave) begin
        m_rr = (m_owner + 1) % N;
        m_owner = -1;
        m_gap = TC;
        m_held = 0;
      end else if (m_held < HM) begin
        m_held++;
      end
    end else if (m_gap > 1) begin
      m_gap--;
    end else begin
      m_gap = 0;
      for (int i = 0; i < N; i++) begin
        if (req_i[(m_rr + i) % N]) begin
          m_owner = (m_rr + i) % N;
          m_held = 1;
          break;
        end
      end
    end
    m_attr = (m_owner >= 0) ? attr_i[m_owner*PA +: PA] : RA;
  endfunction

  // Compare process: every cycle, away from the clock edge.
  always @(negedge clk) begin
    if (model_on) begin
      logic [N-1:0] e_gnt;
      logic         e_oe;
      #2;
      e_gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      e_oe  = (m_owner >= 0) ? oe_req_i[m_owner] : 1'b0;
      chk("model_gnt", gnt_o, e_gnt);
      chk("model_pad_oe", pad_oe_o, e_oe);
      chk("model_pad_in", pad_in_o, e_oe & ((m_owner >= 0) ? out_i[m_owner] : 1'b0));
      chk("model_attr", pad_attributes_o, m_attr);
      chk("model_in_o", in_o, pad_out_i);
      chk("gnt_onehot", ($countones(gnt_o) <= 1), 1);
      model_step();
    end
  end

  logic [N-1:0] order [5];
  int waited;
  int cnt;

  initial begin
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;
    rst_i = 1'b1; req_i = '0; oe_req_i = '0; out_i = '0; attr_i = '0; pad_out_i = 1'b0;
    @(posedge clk);
    model_on = 1'b1;
    @(negedge clk);
    @(negedge clk); rst_i = 1'b0;
    #3;
    chk("reset_gnt", gnt_o, 0);
    chk("reset_oe", pad_oe_o, 0);
    chk("reset_pad_in", pad_in_o, 0);
    chk("reset_attr", pad_attributes_o, RA);

    // Single requester 2 driving a 1.
    @(negedge clk);
    req_i = 4'b0100; oe_req_i = 4'b0100; out_i = 4'b0100;
    attr_i[2*PA +: PA] = 16'hA5A5;
    @(negedge clk); pad_out_i = 1'b1; #3;
    chk("t1_gnt", gnt_o, 4'b0100);
    chk("t1_oe", pad_oe_o, 1);
    chk("t1_pad_in", pad_in_o, 1);
    chk("t6_attr_grant", pad_attributes_o, 16'hA5A5);
    chk("t6_in_o_hi", in_o, 1);

    // Owner 2 releases while 0 waits: two-cycle turnaround.
    @(negedge clk); req_i = 4'b0001; pad_out_i = 1'b0;
    @(negedge clk); pad_out_i = 1'b1; #3;
    chk("t2_turn1_gnt", gnt_o, 0);
    chk("t2_turn1_oe", pad_oe_o, 0);
    chk("t6_attr_turn", pad_attributes_o, RA);
    chk("t6_in_o_turn", in_o, 1);
    @(negedge clk); pad_out_i = 1'b0; #3;
    chk("t2_turn2_gnt", gnt_o, 0);
    chk("t2_turn2_oe", pad_oe_o, 0);
    @(negedge clk); #3;
    chk("t2_new_gnt", gnt_o, 4'b0001);

    // All request; each owner drops for one cycle -> 0,1,2,3,0.
    @(negedge clk); req_i = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      waited = 0;
      while (gnt_o == '0 && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      chk("t3_rr_order", gnt_o, order[g]);
      req_i = 4'b1111 & ~gnt_o;
      @(negedge clk); req_i = 4'b1111;
    end

    // Reset while the owner is driving.
    oe_req_i = 4'b1111;
    waited = 0;
    while (gnt_o == '0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("t5_pre_oe", pad_oe_o, 1);
    rst_i = 1'b1;
    @(negedge clk); rst_i = 1'b0;
    chk("t5_oe", pad_oe_o, 0);
    chk("t5_gnt", gnt_o, 0);
    chk("t5_attr", pad_attributes_o, RA);
    req_i = '0;
    repeat (4) @(negedge clk);

`ifdef PAD_SHARE_PREEMPT_EN
    req_i = 4'b0010;
    waited = 0;
    while (gnt_o == '0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    req_i = 4'b1010;
    cnt = 0;
    while (gnt_o == 4'b0010 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk("t4_hold_cycles", cnt, 16);
    chk("t4_turn1", gnt_o, 0);
    @(negedge clk);
    chk("t4_turn2", gnt_o, 0);
    @(negedge clk);
    chk("t4_new_owner", gnt_o, 4'b1000);
    req_i = 4'b1000;
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (gnt_o == 4'b1000) cnt++;
    end
    chk("t4_sole_kept", cnt, 100);
    req_i = '0;
    repeat (4) @(negedge clk);
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(7) == 0) req_i[b] = ~req_i[b];
      end
      oe_req_i  = N'($urandom);
      out_i     = N'($urandom);
      pad_out_i = 1'($urandom);
      if ($urandom_range(15) == 0) attr_i = {$urandom, $urandom};
      rst_i = ($urandom_range(499) == 0);
    end
    @(negedge clk); rst_i = 1'b0;
    repeat (3) @(negedge clk);
    #4;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
